// File: rtl/inst_enc.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word through one
// registered valid/ready stage, tagging each word with a running byte address.
module inst_enc #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter logic [31:0]          NOP_WORD  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       ir,
  output logic              err,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_sticky,
  output logic [15:0]       word_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic        accept;
  logic        fire;
  logic [31:0] enc_word;
  logic        enc_err;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  // Format select and immediate range check; anything illegal becomes NOP_WORD.
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b1;
    unique case (opcode)
      OP_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err  = 1'b0;
      end
      OP_LOAD, OP_IMM, OP_JALR: begin
        if (imm[31:12] == 20'd0) begin
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
          enc_err  = 1'b0;
        end
      end
      OP_STORE: begin
        if (imm[31:12] == 20'd0) begin
          enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
          enc_err  = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (imm[31:13] == 19'd0 && !imm[0]) begin
          enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
          enc_err  = 1'b0;
        end
      end
      OP_LUI, OP_AUIPC: begin
        if (imm[11:0] == 12'd0) begin
          enc_word = {imm[31:12], rd, opcode};
          enc_err  = 1'b0;
        end
      end
      OP_JAL: begin
        if (imm[31:21] == 11'd0 && !imm[0]) begin
          enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
          enc_err  = 1'b0;
        end
      end
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Output stage; address and counters advance on each fire, so the address
  // always belongs to the word currently presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      ir         <= 32'd0;
      err        <= 1'b0;
      out_addr   <= BASE_ADDR;
      err_sticky <= 1'b0;
      word_cnt   <= 16'd0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        ir        <= enc_word;
        err       <= enc_err;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
      if (fire) begin
        out_addr <= out_addr + ADDR_W'(4);
        word_cnt <= word_cnt + 16'd1;
        if (err) err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_enc.sv
// Directed bench for inst_enc: encoding table streamed back to back, then stall,
// address wrap and mid-operation reset sequences.
module tb_inst_enc;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned NVEC   = 23;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       ir;
  logic              err;
  logic [ADDR_W-1:0] out_addr;
  logic              err_sticky;
  logic [15:0]       word_cnt;

  inst_enc #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .ir(ir), .err(err), .out_addr(out_addr), .err_sticky(err_sticky),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_ir;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NVEC];

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_addr;
  logic [15:0] exp_cnt;
  logic        exp_sticky;
  logic        seen_top;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    opcode = v.op; rd = v.rd; funct3 = v.f3; rs1 = v.rs1;
    rs2 = v.rs2; funct7 = v.f7; imm = v.imm;
  endtask

  task automatic check_state(input string tag, input logic ov);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_addr"}, 32'(out_addr), 32'(exp_addr));
    chk({tag, ".word_cnt"}, 32'(word_cnt), 32'(exp_cnt));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(exp_sticky));
  endtask

  initial begin
    //           op     rd    f3    rs1   rs2   f7     imm            exp_ir         err
    vecs[0]  = '{7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'h00, 32'h0000_0005, 32'h0051_0093, 1'b0};
    vecs[1]  = '{7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'h0000_0008, 32'h0020_8463, 1'b0};
    vecs[2]  = '{7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0};
    vecs[3]  = '{7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    vecs[4]  = '{7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0};
    vecs[5]  = '{7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'h0000_0000, 32'h4020_81B3, 1'b0};
    vecs[6]  = '{7'h23, 5'd7, 3'd2, 5'd1, 5'd2, 7'h00, 32'h0000_000C, 32'h0020_A623, 1'b0};
    vecs[7]  = '{7'h03, 5'd5, 3'd2, 5'd6, 5'd0, 7'h00, 32'h0000_0004, 32'h0043_2283, 1'b0};
    vecs[8]  = '{7'h67, 5'd0, 3'd0, 5'd1, 5'd0, 7'h00, 32'h0000_0000, 32'h0000_8067, 1'b0};
    vecs[9]  = '{7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0FFF, 32'hFFF0_0093, 1'b0};
    vecs[10] = '{7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_1000, 32'h0000_0013, 1'b1};
    vecs[11] = '{7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0006, 32'h0000_0363, 1'b0};
    vecs[12] = '{7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0003, 32'h0000_0013, 1'b1};
    vecs[13] = '{7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_1000, 32'h8000_0063, 1'b0};
    vecs[14] = '{7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_2000, 32'h0000_0013, 1'b1};
    vecs[15] = '{7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0010_0000, 32'h8000_006F, 1'b0};
    vecs[16] = '{7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0020_0000, 32'h0000_0013, 1'b1};
    vecs[17] = '{7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0001, 32'h0000_0013, 1'b1};
    vecs[18] = '{7'h17, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFF_F000, 32'hFFFF_F017, 1'b0};
    vecs[19] = '{7'h37, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h1234_5001, 32'h0000_0013, 1'b1};
    vecs[20] = '{7'h7F, 5'd1, 3'd0, 5'd2, 5'd3, 7'h00, 32'h0000_0000, 32'h0000_0013, 1'b1};
    vecs[21] = '{7'h23, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0FFF, 32'hFE00_0FA3, 1'b0};
    vecs[22] = '{7'h23, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_1000, 32'h0000_0013, 1'b1};

    exp_addr = 8'h00; exp_cnt = 16'd0; exp_sticky = 1'b0; seen_top = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[0]);
    tick();
    tick();
    // Input offered during reset must be ignored
    in_valid = 1'b1;
    tick();
    check_state("reset", 1'b0);
    chk("reset.ir", ir, 32'h0);
    chk("reset.err", 32'(err), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_reset.out_valid", 32'(out_valid), 32'h0);
    chk("post_reset.in_ready", 32'(in_ready), 32'h1);

    // Table streamed back to back with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
      check_state($sformatf("vec%0d", i), 1'b1);
      chk($sformatf("vec%0d.ir", i), ir, vecs[i].exp_ir);
      chk($sformatf("vec%0d.err", i), 32'(err), 32'(vecs[i].exp_err));
      exp_addr   = exp_addr + 8'd4;
      exp_cnt    = exp_cnt + 16'd1;
      exp_sticky = exp_sticky | vecs[i].exp_err;
    end
    in_valid = 1'b0;
    tick();
    check_state("drain", 1'b0);

    // Stall: consumer not ready for 5 cycles while a second word waits
    out_ready = 1'b0;
    drive(vecs[0]);
    in_valid = 1'b1;
    tick();
    chk("stall.first_ir", ir, 32'h0051_0093);
    drive(vecs[3]);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d.in_ready", k), 32'(in_ready), 32'h0);
      chk($sformatf("stall%0d.ir", k), ir, 32'h0051_0093);
      check_state($sformatf("stall%0d", k), 1'b1);
    end
    out_ready = 1'b1;
    tick();
    exp_addr = exp_addr + 8'd4; exp_cnt = exp_cnt + 16'd1;
    chk("release.ir", ir, 32'h1234_52B7);
    check_state("release", 1'b1);
    in_valid = 1'b0;
    tick();
    exp_addr = exp_addr + 8'd4; exp_cnt = exp_cnt + 16'd1;
    check_state("release_drain", 1'b0);

    // Stream until the address reaches the top of the space, then wrap
    drive(vecs[0]);
    in_valid = 1'b1;
    for (int k = 0; k < 80 && !seen_top; k++) begin
      tick();
      check_state($sformatf("wrap%0d", k), 1'b1);
      if (out_addr == 8'hFC) seen_top = 1'b1;
      exp_addr = exp_addr + 8'd4;
      exp_cnt  = exp_cnt + 16'd1;
    end
    chk("wrap.reached_top", 32'(seen_top), 32'h1);
    in_valid = 1'b0;
    tick();
    chk("wrap.out_addr_zero", 32'(out_addr), 32'h0);
    check_state("wrap_drain", 1'b0);

    // Reset while a word is stalled at the output
    out_ready = 1'b0;
    drive(vecs[2]);
    in_valid = 1'b1;
    tick();
    chk("pre_rst.out_valid", 32'(out_valid), 32'h1);
    chk("pre_rst.ir", ir, 32'h0010_00EF);
    rst = 1'b1;
    tick();
    exp_addr = 8'h00; exp_cnt = 16'd0; exp_sticky = 1'b0;
    check_state("mid_rst", 1'b0);
    chk("mid_rst.ir", ir, 32'h0);
    chk("mid_rst.err", 32'(err), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("after_rst.in_ready", 32'(in_ready), 32'h1);
    check_state("after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
